// File: rtl/aud_rec_i2s_multi_if.sv
// SRAM write-request channel between the I2S recorder (master) and the SRAM arbiter (slave).
interface aud_rec_i2s_multi_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 20
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ch;

    modport master (output wr_valid, output wr_addr, output wr_data, output wr_ch, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, input wr_ch, output wr_ready);
endinterface

// File: rtl/aud_rec_i2s_multi.sv
// Multi-channel I2S capture engine streaming samples into the SRAM write port.
// Optional AUD_REC_MONO_MIX_EN: with NUM_CH=2, store one (L+R)>>>1 word per frame.
module aud_rec_i2s_multi #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DEPTH  = 2**ADDR_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_lrc,
    input  logic                i_adcdat,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_stop,
    aud_rec_i2s_multi_if.master wr_if,
    output logic [ADDR_W:0]     o_rec_len,
    output logic                o_busy,
    output logic                o_paused,
    output logic                o_full,
    output logic                o_ovf
);
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {StIdle, StWaitFrm, StShift, StStore, StPaused} state_t;

    state_t            r_state, w_state_d;
    logic              r_lrc;
    logic              r_cap;
    logic              r_ch;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_pause_pend;
    logic              r_wr_valid;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_wr_ch;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_rec_len;
    logic              r_full;
    logic              r_ovf;

    logic              w_edge, w_fall, w_wr_done, w_full_hit, w_last_bit, w_last_ch;
    logic              w_clear, w_pause_set, w_arm, w_shift_en, w_load, w_drop, w_save_left;
    logic [DATA_W-1:0] w_shift_nx, w_store_data;

`ifdef AUD_REC_MONO_MIX_EN
    localparam bit MonoMix = (NUM_CH == 2);
    logic [DATA_W-1:0] r_left;
    logic [DATA_W:0]   w_sum;

    // Sign-extended sum keeps the carry so the arithmetic shift cannot overflow.
    assign w_sum        = {r_left[DATA_W-1], r_left} + {r_shift[DATA_W-1], r_shift};
    assign w_store_data = MonoMix ? DATA_W'(w_sum >> 1) : r_shift;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_left <= '0;
        end else if (w_save_left) begin
            r_left <= w_shift_nx;
        end
    end
`else
    localparam bit MonoMix = 1'b0;
    assign w_store_data = r_shift;
`endif

    assign w_edge     = i_lrc != r_lrc;
    assign w_fall     = w_edge & ~i_lrc;
    assign w_wr_done  = r_wr_valid & wr_if.wr_ready;
    assign w_full_hit = w_wr_done & (r_ptr == ADDR_W'(DEPTH - 1));
    assign w_last_bit = r_cap & (r_bit_cnt == CNT_W'(DATA_W - 1));
    assign w_last_ch  = MonoMix | (NUM_CH == 1) | r_ch;
    assign w_shift_nx = {r_shift[DATA_W-2:0], i_adcdat};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_clear     = 1'b0;
        w_pause_set = 1'b0;
        w_arm       = 1'b0;
        w_shift_en  = 1'b0;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        w_save_left = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StWaitFrm;
                    w_clear   = 1'b1;
                end
            end
            StWaitFrm: begin
                if (i_stop) begin
                    w_state_d = StIdle;
                end else if (i_pause) begin
                    w_state_d = StPaused;
                end else if (w_fall) begin
                    w_state_d = StShift;
                    w_arm     = 1'b1;
                end
            end
            StShift: begin
                if (i_stop) begin
                    w_state_d = StIdle;
                end else begin
                    w_pause_set = i_pause;
                    if (w_edge) begin
                        w_arm = 1'b1;
                    end else if (r_cap) begin
                        w_shift_en = 1'b1;
                        if (w_last_bit) begin
                            if (MonoMix && !r_ch) begin
                                w_save_left = 1'b1;
                            end else begin
                                w_state_d = StStore;
                            end
                        end
                    end
                end
            end
            StStore: begin
                if (i_stop) begin
                    w_state_d = StIdle;
                end else begin
                    w_pause_set = i_pause;
                    // A still-pending write wins; the new sample is dropped.
                    if (r_wr_valid && !wr_if.wr_ready) begin
                        w_drop = 1'b1;
                    end else if (!w_full_hit) begin
                        w_load = 1'b1;
                    end
                    if (w_last_ch && (r_pause_pend || i_pause)) begin
                        w_state_d = StPaused;
                    end else begin
                        w_state_d = StShift;
                        w_arm     = w_edge;
                    end
                end
            end
            StPaused: begin
                if (i_stop) begin
                    w_state_d = StIdle;
                end else if (i_start) begin
                    w_state_d = StWaitFrm;
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (w_full_hit) begin
            w_state_d = StIdle;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lrc        <= 1'b0;
            r_cap        <= 1'b0;
            r_ch         <= 1'b0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_pause_pend <= 1'b0;
        end else begin
            r_lrc <= i_lrc;
            if (w_arm) begin
                r_ch      <= i_lrc;
                r_bit_cnt <= '0;
                r_cap     <= (NUM_CH == 2) || !i_lrc;
            end else if (w_shift_en) begin
                r_shift   <= w_shift_nx;
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                if (w_last_bit) begin
                    r_cap <= 1'b0;
                end
            end
            if (w_state_d == StIdle || w_state_d == StPaused) begin
                r_pause_pend <= 1'b0;
            end else if (w_pause_set) begin
                r_pause_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_valid <= 1'b0;
            r_wr_data  <= '0;
            r_wr_ch    <= 1'b0;
            r_ptr      <= '0;
            r_rec_len  <= '0;
            r_full     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_load) begin
                r_wr_valid <= 1'b1;
                r_wr_data  <= w_store_data;
                r_wr_ch    <= MonoMix ? 1'b0 : r_ch;
            end else if (w_wr_done) begin
                r_wr_valid <= 1'b0;
            end
            if (w_clear) begin
                r_ptr     <= '0;
                r_rec_len <= '0;
            end else if (w_wr_done) begin
                r_rec_len <= r_rec_len + (ADDR_W+1)'(1);
                if (!w_full_hit) begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                end
            end
            r_full <= w_clear ? 1'b0 : (r_full | w_full_hit);
            r_ovf  <= w_clear ? 1'b0 : (r_ovf | w_drop);
        end
    end

    assign wr_if.wr_valid = r_wr_valid;
    assign wr_if.wr_addr  = r_ptr;
    assign wr_if.wr_data  = r_wr_data;
    assign wr_if.wr_ch    = r_wr_ch;
    assign o_rec_len      = r_rec_len;
    assign o_busy         = (r_state == StWaitFrm) || (r_state == StShift) || (r_state == StStore);
    assign o_paused       = r_state == StPaused;
    assign o_full         = r_full;
    assign o_ovf          = r_ovf;
endmodule
